// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared FSM state encoding, line metadata and address-split helpers
//          for the set-associative cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_RESPOND   = 3'd4
  } cache_state_e;

  // Tag is kept at full address width; bits above the real tag width stay zero.
  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [31:0] tag;
  } line_meta_t;

  function automatic int offset_width(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int line_size, input int num_sets);
    return 32 - offset_width(line_size) - index_width(num_sets);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_plru.sv
// ============================================================================
// Module : cache_plru
// Brief  : Tree pseudo-LRU for one set: next-state update for a touched way
//          and victim selection from the current tree bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_plru #(
  parameter int NUM_WAYS = 2
) (
  input  logic [NUM_WAYS-2:0]         plru_state,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  output logic [NUM_WAYS-2:0]         plru_next,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way
);

  localparam int c_levels = $clog2(NUM_WAYS);

  // Node n has children 2n+1 (bit 0) and 2n+2 (bit 1); a node bit names the
  // child on the least-recently-used side.
  always_comb begin
    int node;
    node      = 0;
    plru_next = plru_state;
    for (int l = 0; l < c_levels; l++) begin
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        if (n == node) plru_next[n] = ~touch_way[c_levels-1-l];
      end
      node = 2 * node + 1 + (touch_way[c_levels-1-l] ? 1 : 0);
    end
  end

  always_comb begin
    int   node;
    logic w_bit;
    node       = 0;
    w_bit      = 1'b0;
    victim_way = '0;
    for (int l = 0; l < c_levels; l++) begin
      w_bit = 1'b0;
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        if (n == node) w_bit = plru_state[n];
      end
      victim_way[c_levels-1-l] = w_bit;
      node = 2 * node + 1 + (w_bit ? 1 : 0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_assoc_cache.sv
// ============================================================================
// Module : set_assoc_cache
// Brief  : Write-back, write-allocate set-associative cache with tree-PLRU
//          replacement. Define CACHE_STATS_EN to add hit/miss counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 2,
  parameter int NUM_WAYS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [31:0]            dout,
  output logic                   is_hit,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [31:0]            mem_req_addr,
  output logic [LINE_SIZE*8-1:0] mem_req_data,
  input  logic                   mem_resp_valid,
  input  logic [LINE_SIZE*8-1:0] mem_resp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);

  localparam int c_off_w = offset_width(LINE_SIZE);
  localparam int c_idx_w = index_width(NUM_SETS);
  localparam int c_tag_w = tag_width(LINE_SIZE, NUM_SETS);
  localparam int c_way_w = $clog2(NUM_WAYS);
  localparam int c_line_w = LINE_SIZE * 8;

  cache_state_e        r_state;
  logic [31:0]         r_addr;
  logic [31:0]         r_din;
  logic                r_rd;
  logic                r_wr;
  logic                r_out_valid;
  logic                r_hit;
  logic [31:0]         r_dout;
  logic                r_fill_wait;
  logic [c_way_w-1:0]  r_victim;
  line_meta_t          r_meta [NUM_SETS][NUM_WAYS];
  logic [c_line_w-1:0] r_data [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-2:0] r_plru [NUM_SETS];

  logic [c_idx_w-1:0]  w_index;
  logic [31:0]         w_tag;
  logic [c_off_w+2:0]  w_shift;
  logic                w_noop;
  logic                w_hit;
  logic [c_way_w-1:0]  w_hit_way;
  logic                w_inv_found;
  logic [c_way_w-1:0]  w_inv_way;
  logic [c_way_w-1:0]  w_plru_victim;
  logic [c_way_w-1:0]  w_vic_sel;
  logic                w_vic_dirty;
  logic [c_way_w-1:0]  w_touch;
  logic [NUM_WAYS-2:0] w_plru_next;
  logic [c_line_w-1:0] w_hit_line;
  logic [c_line_w-1:0] w_hit_merged;
  logic [c_line_w-1:0] w_fill_line;
  logic [31:0]         w_rd_word;
  logic                w_hit_evt;
  logic                w_fill_evt;
  line_meta_t          w_vic_meta;

  assign w_index = r_addr[c_off_w +: c_idx_w];
  assign w_tag   = 32'(r_addr[31 -: c_tag_w]);
  assign w_shift = {r_addr[c_off_w-1:0], 3'b000};
  assign w_noop  = !r_rd && !r_wr;

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_meta[w_index][w].valid && r_meta[w_index][w].tag == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = c_way_w'(w);
      end
      if (!r_meta[w_index][w].valid && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = c_way_w'(w);
      end
    end
  end

  assign w_vic_sel   = w_inv_found ? w_inv_way : w_plru_victim;
  assign w_vic_dirty = r_meta[w_index][w_vic_sel].valid && r_meta[w_index][w_vic_sel].dirty;
  assign w_touch     = (r_state == ST_LOOKUP) ? w_hit_way : r_victim;
  assign w_vic_meta  = r_meta[w_index][r_victim];

  cache_plru #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .plru_state (r_plru[w_index]),
    .touch_way  (w_touch),
    .plru_next  (w_plru_next),
    .victim_way (w_plru_victim)
  );

  // Stores merge the 32-bit word into the line at the byte offset.
  always_comb begin
    w_hit_line   = r_data[w_index][w_hit_way];
    w_rd_word    = w_hit_line[w_shift +: 32];
    w_hit_merged = w_hit_line;
    w_hit_merged[w_shift +: 32] = r_din;
    w_fill_line  = mem_resp_data;
    if (r_wr) w_fill_line[w_shift +: 32] = r_din;
  end

  assign w_hit_evt  = (r_state == ST_LOOKUP) && !w_noop && w_hit;
  assign w_fill_evt = (r_state == ST_REFILL) && r_fill_wait && mem_resp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_din       <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_dout      <= '0;
      r_fill_wait <= 1'b0;
      r_victim    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) r_meta[s][w] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (is_input_valid) begin
            r_addr  <= addr;
            r_din   <= din;
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_state <= ST_LOOKUP;
            // A no-op answers immediately and leaves the cache untouched.
            if (!mem_read && !mem_write) begin
              r_out_valid <= 1'b1;
              r_hit       <= 1'b1;
            end
          end
        end
        ST_LOOKUP: begin
          if (w_noop) begin
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_out_valid     <= 1'b1;
            r_hit           <= 1'b1;
            r_dout          <= r_wr ? r_din : w_rd_word;
            r_plru[w_index] <= w_plru_next;
            if (r_wr) r_meta[w_index][w_hit_way].dirty <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_victim    <= w_vic_sel;
            r_fill_wait <= 1'b0;
            r_state     <= w_vic_dirty ? ST_WRITEBACK : ST_REFILL;
          end
        end
        ST_WRITEBACK: begin
          if (mem_req_ready) r_state <= ST_REFILL;
        end
        ST_REFILL: begin
          if (!r_fill_wait) begin
            if (mem_req_ready) r_fill_wait <= 1'b1;
          end else if (mem_resp_valid) begin
            r_meta[w_index][r_victim] <= {1'b1, r_wr, w_tag};
            r_plru[w_index] <= w_plru_next;
            r_out_valid     <= 1'b1;
            r_hit           <= 1'b0;
            r_dout          <= r_wr ? r_din : mem_resp_data[w_shift +: 32];
            r_state         <= ST_RESPOND;
          end
        end
        ST_RESPOND: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_hit_evt && r_wr) r_data[w_index][w_hit_way] <= w_hit_merged;
      if (w_fill_evt)        r_data[w_index][r_victim]  <= w_fill_line;
    end
  end

  assign is_ready        = (r_state == ST_IDLE);
  assign is_output_valid = r_out_valid;
  assign is_hit          = r_hit;
  assign dout            = r_dout;
  assign mem_req_valid   = (r_state == ST_WRITEBACK) || ((r_state == ST_REFILL) && !r_fill_wait);
  assign mem_req_write   = (r_state == ST_WRITEBACK);
  assign mem_req_addr    = (r_state == ST_WRITEBACK)
                         ? ((w_vic_meta.tag << (c_off_w + c_idx_w)) | (32'(w_index) << c_off_w))
                         : {r_addr[31:c_off_w], {c_off_w{1'b0}}};
  assign mem_req_data    = r_data[w_index][r_victim];

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_evt && r_hit_count != 32'hFFFF_FFFF)   r_hit_count  <= r_hit_count + 32'd1;
      if (w_fill_evt && r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
// ============================================================================
// Module : tb_set_assoc_cache
// Brief  : Directed table-driven bench for set_assoc_cache with a behavioural
//          backing memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_set_assoc_cache;

  localparam int LINE_SIZE = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  set_assoc_cache #(
    .LINE_SIZE (LINE_SIZE),
    .NUM_SETS  (2),
    .NUM_WAYS  (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data)
`ifdef CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event expected event within bound", name);
  endtask

  // Behavioural backing memory; untouched lines read as 0xD0000000 + address.
  logic [127:0] mem_model [logic [31:0]];
  int           stall    = 0;
  int           fill_lat = 1;
  int           fill_cnt = 0;
  bit           fill_pend = 0;
  logic [31:0]  fill_addr;
  int           n_rd = 0;
  int           n_wr = 0;
  logic [31:0]  rd_addr  = '0;
  logic [31:0]  wb_addr  = '0;
  logic [31:0]  wb_word0 = '0;
  logic         hs_write;
  logic [31:0]  hs_addr;
  logic [127:0] hs_data;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {32'hD000000C + a, 32'hD0000008 + a, 32'hD0000004 + a, 32'hD0000000 + a};
  endfunction

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (mem_req_ready === 1'b1) begin
        if (hs_write) begin
          mem_model[hs_addr] = hs_data;
          n_wr++;
          wb_addr  = hs_addr;
          wb_word0 = hs_data[31:0];
        end else begin
          n_rd++;
          rd_addr   = hs_addr;
          fill_addr = hs_addr;
          fill_pend = 1'b1;
          fill_cnt  = fill_lat;
        end
      end
      if (fill_pend) begin
        if (fill_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = line_of(fill_addr);
          fill_pend      = 1'b0;
        end else begin
          fill_cnt--;
        end
      end
      if (mem_req_valid === 1'b1 && stall > 0) begin
        stall--;
        mem_req_ready = 1'b0;
      end else begin
        mem_req_ready = (mem_req_valid === 1'b1);
      end
      hs_write = mem_req_write;
      hs_addr  = mem_req_addr;
      hs_data  = mem_req_data;
    end
  end

  task automatic do_req(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, output logic hit, output logic [31:0] dv,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!is_ready && g < 100) begin @(negedge clk); g++; end
    if (!is_ready) timeout("ready_wait");
    addr = a; mem_read = rd; mem_write = wr; din = d; is_input_valid = 1'b1;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    lat = 1;
    while (!is_output_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!is_output_valid) timeout("response_wait");
    hit = is_hit;
    dv  = dout;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic        rd;
    logic        wr;
    logic [31:0] d;
    logic        exp_hit;
    logic [31:0] exp_dout;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_rd_addr;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_word0;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic        hit;
    logic [31:0] dv;
    int          lat;
    int          rd0;
    int          wr0;
    int          g;
    int          pulses;

    mem_model[32'h10] = {32'hD000001C, 32'hD0000018, 32'hD0000014, 32'hA5A5A5A5};

    vecs[0]  = '{"ld10_miss",  32'h10, 1, 0, 0,     0, 32'hA5A5A5A5, 0, 1, 0, 32'h10, 0, 0};
    vecs[1]  = '{"ld10_hit",   32'h10, 1, 0, 0,     1, 32'hA5A5A5A5, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{"ld14_hit",   32'h14, 1, 0, 0,     1, 32'hD0000014, 2, 0, 0, 0, 0, 0};
    vecs[3]  = '{"st00_miss",  32'h00, 0, 1, 32'h11, 0, 32'h11,      0, 1, 0, 32'h00, 0, 0};
    vecs[4]  = '{"st20_miss",  32'h20, 0, 1, 32'h22, 0, 32'h22,      0, 1, 0, 32'h20, 0, 0};
    vecs[5]  = '{"ld40_wb",    32'h40, 1, 0, 0,     0, 32'hD0000040, 0, 1, 1, 32'h40, 32'h00, 32'h11};
    vecs[6]  = '{"ld00_wb",    32'h00, 1, 0, 0,     0, 32'h11,       0, 1, 1, 32'h00, 32'h20, 32'h22};
    vecs[7]  = '{"noop",       32'h40, 0, 0, 0,     1, 32'h11,       1, 0, 0, 0, 0, 0};
    vecs[8]  = '{"ld48_hit",   32'h48, 1, 0, 0,     1, 32'hD0000048, 2, 0, 0, 0, 0, 0};
    vecs[9]  = '{"rdwr48_st",  32'h48, 1, 1, 32'h77, 1, 32'h77,      2, 0, 0, 0, 0, 0};
    vecs[10] = '{"ld48_after", 32'h48, 1, 0, 0,     1, 32'h77,       2, 0, 0, 0, 0, 0};
    vecs[11] = '{"ld30_miss",  32'h30, 1, 0, 0,     0, 32'hD0000030, 0, 1, 0, 32'h30, 0, 0};
    vecs[12] = '{"ld04_hit",   32'h04, 1, 0, 0,     1, 32'hD0000004, 2, 0, 0, 0, 0, 0};

    reset = 1'b1; is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_is_ready", 32'(is_ready), 32'd1);
    chk("rst_out_valid", 32'(is_output_valid), 32'd0);
    chk("rst_is_hit", 32'(is_hit), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_write", 32'(mem_req_write), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      rd0 = n_rd;
      wr0 = n_wr;
      do_req(vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].d, hit, dv, lat);
      chk({vecs[i].name, "_hit"}, 32'(hit), 32'(vecs[i].exp_hit));
      chk({vecs[i].name, "_dout"}, dv, vecs[i].exp_dout);
      if (vecs[i].exp_lat != 0) chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_n_fill"}, 32'(n_rd - rd0), 32'(vecs[i].exp_rd));
      chk({vecs[i].name, "_n_wb"}, 32'(n_wr - wr0), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_rd != 0) chk({vecs[i].name, "_fill_addr"}, rd_addr, vecs[i].exp_rd_addr);
      if (vecs[i].exp_wr != 0) begin
        chk({vecs[i].name, "_wb_addr"}, wb_addr, vecs[i].exp_wb_addr);
        chk({vecs[i].name, "_wb_word0"}, wb_word0, vecs[i].exp_wb_word0);
      end
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("stats_hit_count", hit_count, 32'd1);
        chk("stats_miss_count", miss_count, 32'd1);
      end
`endif
    end

    // Fill request held off for five cycles must stay stable.
    stall = 5;
    @(negedge clk);
    g = 0;
    while (!is_ready && g < 100) begin @(negedge clk); g++; end
    addr = 32'h50; mem_read = 1'b1; mem_write = 1'b0; is_input_valid = 1'b1;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    #1;
    g = 0;
    while (!mem_req_valid && g < 20) begin @(negedge clk); #1; g++; end
    if (!mem_req_valid) timeout("stall_req_wait");
    for (int k = 0; k < 5; k++) begin
      chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_req_addr", mem_req_addr, 32'h50);
      chk("stall_req_write", 32'(mem_req_write), 32'd0);
      chk("stall_is_ready", 32'(is_ready), 32'd0);
      @(negedge clk); #1;
    end
    g = 0;
    while (!is_output_valid && g < 50) begin @(negedge clk); g++; end
    if (!is_output_valid) timeout("stall_resp_wait");
    chk("stall_dout", dout, 32'hD0000050);
    chk("stall_is_hit", 32'(is_hit), 32'd0);

    // Reset while waiting on a slow fill; the late response must be ignored.
    fill_lat = 8;
    rd0 = n_rd;
    @(negedge clk);
    g = 0;
    while (!is_ready && g < 100) begin @(negedge clk); g++; end
    addr = 32'h60; mem_read = 1'b1; is_input_valid = 1'b1;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    #1;
    g = 0;
    while (n_rd == rd0 && g < 100) begin @(negedge clk); #1; g++; end
    if (n_rd == rd0) timeout("refill_handshake_wait");
    reset = 1'b1;
    @(negedge clk); #1;
    chk("refill_rst_is_ready", 32'(is_ready), 32'd1);
    chk("refill_rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("refill_rst_dout", dout, 32'd0);
    reset = 1'b0;
    pulses = 0;
    g = 0;
    while ((fill_pend || g < 3) && g < 50) begin
      @(negedge clk); #1;
      if (is_output_valid) pulses++;
      g++;
    end
    chk("late_resp_sent", 32'(fill_pend), 32'd0);
    chk("late_resp_ignored", 32'(pulses), 32'd0);
    chk("late_resp_is_ready", 32'(is_ready), 32'd1);
    fill_lat = 1;
    rd0 = n_rd;
    do_req(32'h10, 1'b1, 1'b0, 32'd0, hit, dv, lat);
    chk("post_rst_ld10_hit", 32'(hit), 32'd0);
    chk("post_rst_ld10_dout", dv, 32'hA5A5A5A5);
    chk("post_rst_ld10_fill", 32'(n_rd - rd0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
